// File: rtl/seq_miter_pkg.sv
// seq_miter_pkg: shared types and constants for the sequential miter checker.
//   state_t    : checker FSM states (IDLE, RUN, PASS, FAIL)
//   LFSR_W     : stimulus LFSR width
//   LFSR_TAPS  : feedback mask for the right-shifting Fibonacci form of
//                x^16 + x^14 + x^13 + x^11 + 1 (bits 0,2,3,5)
//   DEF_SEED   : default LFSR seed
//   ZERO_SEED  : substitute used when a zero seed is requested
package seq_miter_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
    localparam logic [LFSR_W-1:0] DEF_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] ZERO_SEED = 16'h0001;
    // An all-zero Fibonacci LFSR locks up, so a zero seed is replaced.
    function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
        return s == '0 ? ZERO_SEED : s;
    endfunction
endpackage

// File: rtl/seq_miter_lfsr.sv
// seq_miter_lfsr: 16-bit Fibonacci LFSR producing the miter stimulus.
//   clk, rst_n : clock, asynchronous active-low reset (state <= RST_VAL)
//   load       : load seed (has priority over advance)
//   seed       : value loaded on load
//   advance    : shift one step
//   state      : current LFSR contents
module seq_miter_lfsr import seq_miter_pkg::*; #(
    parameter logic [LFSR_W-1:0] RST_VAL = DEF_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= RST_VAL;
        else if (load) state <= seed;
        else if (advance) state <= {^(state & LFSR_TAPS), state[LFSR_W-1:1]};
endmodule

// File: rtl/seq_miter_checker.sv
// seq_miter_checker: bounded sequential equivalence checker for two CUTs.
//   Drives a shared LFSR stimulus to both CUTs and compares their outputs
//   for depth_i cycles, masking the first LAT cycles.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start_i        : arm a run (ignored while busy)
//   depth_i        : RUN cycles to check, sampled on start_i
//   stim_o         : stimulus to both CUTs, stim_vld_o high while running
//   out_a_i/out_b_i: CUT outputs
//   busy_o, done_o, pass_o : RUN / PASS-or-FAIL / PASS
//   fail_cycle_o   : RUN cycle of first mismatch
//   diff_o         : out_a_i ^ out_b_i at first mismatch
//   Optional (SEQ_MITER_TRACE_EN): fail_stim_o, fail_lfsr_o hold the stimulus
//   and full LFSR state of the first mismatching cycle for replay.
module seq_miter_checker import seq_miter_pkg::*; #(
    parameter int                IN_W      = 1,
    parameter int                OUT_W     = 1,
    parameter int                DEPTH_W   = 16,
    parameter int                LAT       = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED = DEF_SEED
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [DEPTH_W-1:0] depth_i,
    output logic [IN_W-1:0]    stim_o,
    output logic               stim_vld_o,
    input  logic [OUT_W-1:0]   out_a_i,
    input  logic [OUT_W-1:0]   out_b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [DEPTH_W-1:0] fail_cycle_o,
    output logic [OUT_W-1:0]   diff_o
`ifdef SEQ_MITER_TRACE_EN
    ,
    output logic [IN_W-1:0]    fail_stim_o,
    output logic [LFSR_W-1:0]  fail_lfsr_o
`endif
);
    localparam logic [LFSR_W-1:0] SEED = fix_seed(LFSR_SEED);
    state_t state, nxt;
    logic [DEPTH_W-1:0] cyc, depth_q;
    logic [LFSR_W-1:0] lfsr;
    logic arm, cmp_en, mis, last;
    assign arm = start_i && state != RUN;
    assign last = cyc == depth_q - 1'b1;
    assign mis = state == RUN && cmp_en && out_a_i != out_b_i;
    if (LAT == 0) begin : g_nolat
        assign cmp_en = 1'b1;
    end else begin : g_lat
        assign cmp_en = cyc >= DEPTH_W'(LAT);
    end
    seq_miter_lfsr #(.RST_VAL(SEED)) u_lfsr (
        .clk(clk), .rst_n(rst_n), .load(arm), .seed(SEED), .advance(busy_o), .state(lfsr)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    // A mismatch on the final cycle wins over completion.
    always_comb begin
        nxt = arm ? (depth_i == '0 ? PASS : RUN)
            : state == RUN ? (mis ? FAIL : last ? PASS : RUN)
            : state;
    end
    always_comb begin
        busy_o = state == RUN;
        done_o = state == PASS || state == FAIL;
        pass_o = state == PASS;
        stim_vld_o = busy_o;
        stim_o = busy_o ? lfsr[IN_W-1:0] : '0;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cyc <= '0;
            depth_q <= '0;
            fail_cycle_o <= '0;
            diff_o <= '0;
        end else if (arm) begin
            cyc <= '0;
            depth_q <= depth_i;
            fail_cycle_o <= '0;
            diff_o <= '0;
        end else if (state == RUN) begin
            cyc <= &cyc ? cyc : cyc + 1'b1;
            if (mis) begin
                fail_cycle_o <= cyc;
                diff_o <= out_a_i ^ out_b_i;
            end
        end
`ifdef SEQ_MITER_TRACE_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            fail_stim_o <= '0;
            fail_lfsr_o <= '0;
        end else if (arm) begin
            fail_stim_o <= '0;
            fail_lfsr_o <= '0;
        end else if (mis) begin
            fail_stim_o <= stim_o;
            fail_lfsr_o <= lfsr;
        end
`endif
endmodule

// File: tb/tb_seq_miter_checker.sv
// tb_seq_miter_checker: directed bench; dut uses LAT=1, dut0 uses LAT=0 on the same stimulus.
module tb_seq_miter_checker;
    logic clk = 0, rst_n = 0, start = 0;
    logic [15:0] depth = 0;
    logic stim, vld, busy, done, pass, diff;
    logic stim0, vld0, busy0, done0, pass0, diff0;
    logic [15:0] fcyc, fcyc0;
    logic cut_q = 0;
    logic [15:0] tcyc = 16'hFFFF, inj_at = 16'hFFFF;
    logic out_a, out_b;
    logic [15:0] trace_lfsr = 0;
    logic trace_stim = 0;
    int total = 0, bad = 0;
`ifdef SEQ_MITER_TRACE_EN
    logic fstim, fstim0;
    logic [15:0] flfsr, flfsr0;
`endif

    assign out_a = cut_q;
    assign out_b = cut_q ^ (tcyc == inj_at);

    seq_miter_checker #(.LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .depth_i(depth),
        .stim_o(stim), .stim_vld_o(vld), .out_a_i(out_a), .out_b_i(out_b),
        .busy_o(busy), .done_o(done), .pass_o(pass), .fail_cycle_o(fcyc), .diff_o(diff)
`ifdef SEQ_MITER_TRACE_EN
        , .fail_stim_o(fstim), .fail_lfsr_o(flfsr)
`endif
    );
    seq_miter_checker #(.LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .depth_i(depth),
        .stim_o(stim0), .stim_vld_o(vld0), .out_a_i(out_a), .out_b_i(out_b),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .fail_cycle_o(fcyc0), .diff_o(diff0)
`ifdef SEQ_MITER_TRACE_EN
        , .fail_stim_o(fstim0), .fail_lfsr_o(flfsr0)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cut_q <= stim;
        tcyc <= start ? 16'd0 : tcyc + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] adv(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic go(input int d);
        start = 1;
        depth = 16'(d);
        @(negedge clk);
        start = 0;
    endtask

    task automatic run(input string tag, input int n_exp, input int restart_at);
        logic [15:0] m = 16'hACE1;
        int n = 0;
        while (busy && n < 300) begin
            chk({tag, "_stim"}, 32'(stim), 32'(m[0]));
            if (n == 0) chk({tag, "_vld"}, 32'(vld), 1);
            if (n == 37) begin
                trace_lfsr = m;
                trace_stim = m[0];
            end
            start = (n == restart_at);
            @(negedge clk);
            start = 0;
            m = adv(m);
            n++;
        end
        chk({tag, "_cycles"}, n, n_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_vld", 32'(vld), 0);
        chk("rst_stim", 32'(stim), 0);
        chk("rst_fcyc", 32'(fcyc), 0);
        chk("rst_diff", 32'(diff), 0);
        rst_n = 1;
        @(negedge clk);

        go(100);
        run("t1", 100, -1);
        chk("t1_done", 32'(done), 1);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_fcyc", 32'(fcyc), 0);
        chk("t1_vld", 32'(vld), 0);
        chk("t1_stim", 32'(stim), 0);
        chk("t1_pass0", 32'(pass0), 1);
        repeat (3) @(negedge clk);
        chk("t1_hold", 32'(pass), 1);

        inj_at = 37;
        go(100);
        run("t2", 38, -1);
        chk("t2_done", 32'(done), 1);
        chk("t2_pass", 32'(pass), 0);
        chk("t2_fcyc", 32'(fcyc), 37);
        chk("t2_diff", 32'(diff), 1);
        chk("t2_fcyc0", 32'(fcyc0), 37);
`ifdef SEQ_MITER_TRACE_EN
        chk("t2_fstim", 32'(fstim), 32'(trace_stim));
        chk("t2_flfsr", 32'(flfsr), 32'(trace_lfsr));
`endif
        repeat (3) @(negedge clk);
        chk("t2_hold", 32'(fcyc), 37);

        inj_at = 0;
        go(10);
        run("t3", 10, -1);
        chk("t3_pass", 32'(pass), 1);
        chk("t3_fcyc", 32'(fcyc), 0);
        chk("t3_diff", 32'(diff), 0);
        chk("t3_done0", 32'(done0), 1);
        chk("t3_pass0", 32'(pass0), 0);
        chk("t3_fcyc0", 32'(fcyc0), 0);
        chk("t3_diff0", 32'(diff0), 1);

        inj_at = 16'hFFFF;
        go(0);
        chk("t4_vld", 32'(vld), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_done", 32'(done), 1);
        chk("t4_pass", 32'(pass), 1);
        chk("t4_pass0", 32'(pass0), 1);

        inj_at = 0;
        go(1);
        run("t4b", 1, -1);
        chk("t4b_pass", 32'(pass), 1);
        chk("t4b_done0", 32'(done0), 1);
        chk("t4b_pass0", 32'(pass0), 0);
        chk("t4b_fcyc0", 32'(fcyc0), 0);

        inj_at = 16'hFFFF;
        go(100);
        repeat (50) @(negedge clk);
        chk("t5_busy_pre", 32'(busy), 1);
        rst_n = 0;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_vld", 32'(vld), 0);
        chk("t5_stim", 32'(stim), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_pass", 32'(pass), 0);
        chk("t5_fcyc", 32'(fcyc), 0);
        chk("t5_diff", 32'(diff), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        go(100);
        run("t5r", 100, -1);
        chk("t5r_pass", 32'(pass), 1);

        go(30);
        run("t6", 30, 10);
        chk("t6_done", 32'(done), 1);
        chk("t6_pass", 32'(pass), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
